// File: rtl/router_1xn.sv
// router_1xn: byte-serial packet router, one input port to NUM_CH buffered outputs.
// Packets are header (dest + LEN), LEN payload words and an XOR parity word; every
// word of a routed packet lands in the destination FIFO. Stale channels are flushed
// after TIMEOUT unread cycles.
module router_1xn #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CH  = 3,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TIMEOUT = 30
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [DATA_W-1:0]        i_data_in,
  input  logic                     i_pkt_valid,
  output logic                     o_busy,
  input  logic [NUM_CH-1:0]        i_read_enb,
  output logic [NUM_CH*DATA_W-1:0] o_data_out,
  output logic [NUM_CH-1:0]        o_vld_out,
  output logic                     o_err,
  output logic                     o_drop_pkt,
  output logic [NUM_CH-1:0]        o_soft_rst
);

  localparam int unsigned ADDR_W   = $clog2(NUM_CH);
  localparam int unsigned LEN_W    = DATA_W - ADDR_W;
  localparam int unsigned NUM_SLOT = 1 << ADDR_W;
  localparam int unsigned PTR_W    = $clog2(DEPTH);
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StPayload, StParity, StDrop} state_e;

  state_e            r_state, w_state_d;
  logic [ADDR_W-1:0] r_cur, w_cur_d;
  logic [LEN_W-1:0]  r_remain, w_remain_d;
  logic [DATA_W-1:0] r_par;
  logic              r_err;
  logic              r_drop_pkt;
  logic [NUM_CH-1:0] r_soft_rst;

  logic [DATA_W-1:0] r_mem   [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  r_wptr  [NUM_CH];
  logic [PTR_W-1:0]  r_rptr  [NUM_CH];
  logic [CNT_W-1:0]  r_count [NUM_CH];
  logic [TO_W-1:0]   r_tcnt  [NUM_CH];

  logic [ADDR_W-1:0]   w_dest;
  logic [LEN_W-1:0]    w_len;
  logic                w_dest_ok;
  // Padded to a power of two so a decoded out-of-range dest indexes safely.
  logic [NUM_SLOT-1:0] w_full_ext;
  logic [NUM_SLOT-1:0] w_flush_ext;
  logic                w_flush_cur;
  logic                w_accept;
  logic [NUM_CH-1:0]   w_push;
  logic [NUM_CH-1:0]   w_pop;

  assign w_dest      = i_data_in[ADDR_W-1:0];
  assign w_len       = i_data_in[DATA_W-1:ADDR_W];
  assign w_dest_ok   = 32'(w_dest) < NUM_CH;
  assign w_flush_cur = w_flush_ext[r_cur];
  assign w_accept    = i_pkt_valid && !o_busy;
  assign w_pop       = i_read_enb & o_vld_out;
  assign o_err       = r_err;
  assign o_drop_pkt  = r_drop_pkt;
  assign o_soft_rst  = r_soft_rst;

  // Per-channel status: full flags, timeout flush requests, head word and valid.
  always_comb begin
    w_full_ext  = '0;
    w_flush_ext = '0;
    o_vld_out   = '0;
    o_data_out  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_full_ext[k]  = r_count[k] == CNT_W'(DEPTH);
      w_flush_ext[k] = r_tcnt[k] == TO_W'(TIMEOUT);
      o_vld_out[k]   = r_count[k] != '0;
      o_data_out[k*DATA_W +: DATA_W] = o_vld_out[k] ? r_mem[k][r_rptr[k]] : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_cur    <= '0;
      r_remain <= '0;
    end else begin
      r_state  <= w_state_d;
      r_cur    <= w_cur_d;
      r_remain <= w_remain_d;
    end
  end

  // FSM next state. r_remain counts payload words left (PAYLOAD) or words to discard
  // minus one (DROP). A flush of the current channel turns the rest into a drop.
  always_comb begin
    w_state_d  = r_state;
    w_cur_d    = r_cur;
    w_remain_d = r_remain;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_cur_d    = w_dest;
          w_remain_d = w_len;
          if (!w_dest_ok || w_flush_ext[w_dest]) w_state_d = StDrop;
          else if (w_len != '0)                  w_state_d = StPayload;
          else                                   w_state_d = StParity;
        end
      end
      StPayload: begin
        if (w_flush_cur) begin
          w_state_d  = StDrop;
          w_remain_d = w_accept ? r_remain - LEN_W'(1) : r_remain;
        end else if (w_accept) begin
          w_remain_d = r_remain - LEN_W'(1);
          if (r_remain == LEN_W'(1)) w_state_d = StParity;
        end
      end
      StParity: begin
        if (w_accept) begin
          w_state_d = StIdle;
        end else if (w_flush_cur) begin
          w_state_d  = StDrop;
          w_remain_d = '0;
        end
      end
      StDrop: begin
        if (w_accept) begin
          if (r_remain == '0) w_state_d = StIdle;
          else                w_remain_d = r_remain - LEN_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM outputs: backpressure and FIFO write decode (a flush discards the write).
  always_comb begin
    o_busy = 1'b0;
    w_push = '0;
    unique case (r_state)
      StIdle:              o_busy = w_dest_ok && w_full_ext[w_dest];
      StPayload, StParity: o_busy = w_full_ext[r_cur];
      default:             o_busy = 1'b0;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      w_push[k] = w_accept && !w_flush_ext[k] &&
                  ((r_state == StIdle && w_dest_ok && w_dest == ADDR_W'(k)) ||
                   ((r_state == StPayload || r_state == StParity) && r_cur == ADDR_W'(k)));
    end
  end

  // Running parity, error flag and drop pulse.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_par      <= '0;
      r_err      <= 1'b0;
      r_drop_pkt <= 1'b0;
    end else begin
      r_drop_pkt <= w_accept && r_state == StIdle && !w_dest_ok;
      if (w_accept) begin
        if (r_state == StIdle) begin
          r_par <= i_data_in;
          r_err <= 1'b0;
        end else if (r_state == StPayload) begin
          r_par <= r_par ^ i_data_in;
        end else if (r_state == StParity && !w_flush_cur) begin
          r_err <= r_par != i_data_in;
        end
      end
    end
  end

  // FIFO pointers, occupancy and timeout counters; flush overrides everything.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_soft_rst <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_wptr[k]  <= '0;
        r_rptr[k]  <= '0;
        r_count[k] <= '0;
        r_tcnt[k]  <= '0;
      end
    end else begin
      r_soft_rst <= w_flush_ext[NUM_CH-1:0];
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_flush_ext[k]) begin
          r_wptr[k]  <= '0;
          r_rptr[k]  <= '0;
          r_count[k] <= '0;
          r_tcnt[k]  <= '0;
        end else begin
          if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_W'(1);
          if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PTR_W'(1);
          if (w_push[k] && !w_pop[k])      r_count[k] <= r_count[k] + CNT_W'(1);
          else if (!w_push[k] && w_pop[k]) r_count[k] <= r_count[k] - CNT_W'(1);
          if (w_pop[k] || !o_vld_out[k]) r_tcnt[k] <= '0;
          else                           r_tcnt[k] <= r_tcnt[k] + TO_W'(1);
        end
      end
    end
  end

  // FIFO storage, left unreset; the head is masked while the channel is empty.
  always_ff @(posedge i_clock) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_push[k]) r_mem[k][r_wptr[k]] <= i_data_in;
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// Directed bench for router_1xn with a word-level scoreboard of expected FIFO contents.
module tb_router_1xn;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [DATA_W-1:0]        data_in = '0;
  logic                     pkt_valid = 1'b0;
  logic                     busy;
  logic [NUM_CH-1:0]        read_enb = '0;
  logic [NUM_CH*DATA_W-1:0] data_out;
  logic [NUM_CH-1:0]        vld_out;
  logic                     err;
  logic                     drop_pkt;
  logic [NUM_CH-1:0]        soft_rst;

  router_1xn #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (16),
    .TIMEOUT(30)
  ) dut (
    .i_clock    (clk),
    .i_reset    (rst),
    .i_data_in  (data_in),
    .i_pkt_valid(pkt_valid),
    .o_busy     (busy),
    .i_read_enb (read_enb),
    .o_data_out (data_out),
    .o_vld_out  (vld_out),
    .o_err      (err),
    .o_drop_pkt (drop_pkt),
    .o_soft_rst (soft_rst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ch;
    logic [7:0] d;
  } sb_t;

  sb_t sb[$];
  int  n_vec  = 0;
  int  n_fail = 0;
  int  cyc    = 0;
  int  pops[NUM_CH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input int k);
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk($sformatf("pop_ch%0d", k), {22'b0, 2'(k), data_out[k*DATA_W +: DATA_W]},
          {22'b0, e.ch, e.d});
    end
    pops[k]++;
  endtask

  // One clock: drive, sample at the falling edge, advance past the rising edge.
  task automatic do_cycle(input bit v, input logic [7:0] d, input logic [2:0] rd,
                          output bit acc);
    pkt_valid = v;
    data_in   = d;
    read_enb  = rd;
    @(negedge clk);
    acc = v && !busy;
    for (int k = 0; k < NUM_CH; k++) begin
      if (rd[k] && vld_out[k]) check_pop(k);
    end
    @(posedge clk);
    #1;
    cyc++;
    pkt_valid = 1'b0;
    read_enb  = '0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit push, input logic [1:0] ch,
                           input bit rd0, output int ncyc);
    bit acc;
    acc  = 1'b0;
    ncyc = 0;
    while (!acc && ncyc < 100) begin
      do_cycle(1'b1, w, (rd0 && (cyc % 2 == 0)) ? 3'b001 : 3'b000, acc);
      ncyc++;
    end
    if (!acc) chk("accept_bound", 32'(acc), 32'd1);
    else if (push) sb.push_back({ch, w});
  endtask

  task automatic drain(input int ch);
    bit acc;
    for (int i = 0; i < 100; i++) begin
      if (!vld_out[ch]) break;
      do_cycle(1'b0, 8'h00, 3'(1 << ch), acc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit         acc;
    int         n;
    int         waited;
    logic [7:0] pkt[$];
    logic [7:0] par;

    for (int k = 0; k < NUM_CH; k++) pops[k] = 0;

    // Reset state
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    rst = 1'b0;
    chk("rst_vld_out", 32'(vld_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_drop_pkt", 32'(drop_pkt), 32'd0);
    chk("rst_soft_rst", 32'(soft_rst), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);

    // Ch1, LEN=3, good parity
    send_word(8'h0D, 1'b1, 2'd1, 1'b0, n);
    chk("t1_vld_after_hdr", 32'(vld_out), 32'b010);
    chk("t1_head_is_hdr", 32'(data_out[15:8]), 32'h0D);
    send_word(8'h11, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h22, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h33, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h0D, 1'b1, 2'd1, 1'b0, n);
    chk("t1_err", 32'(err), 32'd0);
    pops[1] = 0;
    drain(1);
    chk("t1_pops", 32'(pops[1]), 32'd5);

    // Same packet, corrupted parity
    send_word(8'h0D, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h11, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h22, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h33, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h0E, 1'b1, 2'd1, 1'b0, n);
    chk("t2_err_set", 32'(err), 32'd1);
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    chk("t2_err_held", 32'(err), 32'd1);
    drain(1);
    chk("t2_err_held_after_read", 32'(err), 32'd1);
    chk("t2_ch1_empty", 32'(vld_out), 32'd0);

    // Invalid dest=3, LEN=2: dropped
    send_word(8'h0B, 1'b0, 2'd0, 1'b0, n);
    chk("t3_drop_pulse", 32'(drop_pkt), 32'd1);
    chk("t3_err_cleared", 32'(err), 32'd0);
    send_word(8'hAA, 1'b0, 2'd0, 1'b0, n);
    chk("t3_absorb0_cycles", 32'(n), 32'd1);
    chk("t3_drop_one_cycle", 32'(drop_pkt), 32'd0);
    send_word(8'hBB, 1'b0, 2'd0, 1'b0, n);
    chk("t3_absorb1_cycles", 32'(n), 32'd1);
    send_word(8'hCC, 1'b0, 2'd0, 1'b0, n);
    chk("t3_absorb2_cycles", 32'(n), 32'd1);
    chk("t3_no_writes", 32'(vld_out), 32'd0);

    // Ch0, LEN=20 into a 16-deep FIFO: backpressure then slow drain
    pkt = {8'h50};
    par = 8'h50;
    for (int i = 0; i < 20; i++) begin
      pkt.push_back(8'(8'h80 + i));
      par = par ^ 8'(8'h80 + i);
    end
    pkt.push_back(par);
    pops[0] = 0;
    for (int i = 0; i < 16; i++) send_word(pkt[i], 1'b1, 2'd0, 1'b0, n);
    do_cycle(1'b1, pkt[16], 3'b000, acc);
    chk("t4_busy_when_full", 32'(acc), 32'd0);
    for (int i = 16; i < 22; i++) send_word(pkt[i], 1'b1, 2'd0, 1'b1, n);
    chk("t4_err", 32'(err), 32'd0);
    drain(0);
    chk("t4_pops", 32'(pops[0]), 32'd22);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // Ch2 never read: timeout flush
    send_word(8'h02, 1'b1, 2'd2, 1'b0, n);
    chk("t5_vld_rose", 32'(vld_out), 32'b100);
    send_word(8'h02, 1'b1, 2'd2, 1'b0, n);
    waited = 1;
    while (vld_out[2] && waited < 60) begin
      do_cycle(1'b0, 8'h00, 3'b000, acc);
      waited++;
    end
    chk("t5_flush_cycle", 32'(waited), 32'd31);
    chk("t5_soft_rst", 32'(soft_rst), 32'b100);
    chk("t5_vld_cleared", 32'(vld_out), 32'd0);
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    chk("t5_soft_rst_pulse", 32'(soft_rst), 32'd0);
    sb.delete();
    send_word(8'h06, 1'b1, 2'd2, 1'b0, n);
    send_word(8'h5A, 1'b1, 2'd2, 1'b0, n);
    send_word(8'h5C, 1'b1, 2'd2, 1'b0, n);
    chk("t5_err", 32'(err), 32'd0);
    pops[2] = 0;
    drain(2);
    chk("t5_pops", 32'(pops[2]), 32'd3);

    // Reset mid-payload, then a fresh packet to ch0
    send_word(8'h0D, 1'b1, 2'd1, 1'b0, n);
    send_word(8'h11, 1'b1, 2'd1, 1'b0, n);
    rst = 1'b1;
    do_cycle(1'b0, 8'h00, 3'b000, acc);
    rst = 1'b0;
    sb.delete();
    chk("t6_vld_out", 32'(vld_out), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(err), 32'd0);
    send_word(8'h04, 1'b1, 2'd0, 1'b0, n);
    chk("t6_routes_ch0", 32'(vld_out), 32'b001);
    send_word(8'h77, 1'b1, 2'd0, 1'b0, n);
    send_word(8'h73, 1'b1, 2'd0, 1'b0, n);
    chk("t6_err_good", 32'(err), 32'd0);
    pops[0] = 0;
    drain(0);
    chk("t6_pops", 32'(pops[0]), 32'd3);
    chk("t6_all_empty", 32'(vld_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
